// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, requester count and the
// one-hot bit-mask helpers used by the round-robin picker.
package mem_bus_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam logic [N_REQ-1:0] LAST_RESET = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Sets every bit at and above the lowest set bit of x.
    function automatic logic [N_REQ-1:0] set_high_bits(input logic [N_REQ-1:0] x);
        logic [N_REQ-1:0] result;
        logic             acc;
        acc = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            acc       = acc | x[i];
            result[i] = acc;
        end
        return result;
    endfunction

    // Keeps only the lowest set bit of x.
    function automatic logic [N_REQ-1:0] clear_high_bits(input logic [N_REQ-1:0] x);
        logic [N_REQ-1:0] neg;
        neg = ~x + 4'd1;
        return x & neg;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick4.sv
// Round-robin picker for four requesters: prefers the lowest requester strictly above the
// last grant, otherwise wraps to the lowest requester overall.
module rr_pick4
    import mem_bus_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    output logic [N_REQ-1:0] pick
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] pick_masked;
    logic [N_REQ-1:0] pick_any;

    // last=1000 shifts out to zero, so the mask is empty and the pick wraps.
    assign mask        = set_high_bits({last[N_REQ-2:0], 1'b0});
    assign masked_req  = req & mask;
    assign pick_masked = clear_high_bits(masked_req);
    assign pick_any    = clear_high_bits(req);
    assign pick        = (masked_req != '0) ? pick_masked : pick_any;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Responder end of the shared tri-state memory bus: round-robin one-cycle grants with a dead
// cycle between grants, beat capture, and a valid/ready output holding the captured beat.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    input  logic [WIDTH-1:0] bus_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_src
);

    // Output handshake: a beat transfers on any rising edge where out_valid and out_ready are
    // both high; while out_valid is high and out_ready is low, out_data/out_src do not change.

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       last_q;
    logic [3:0]       last_d;
    logic [3:0]       pick;
    logic [3:0]       grant_d;
    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [3:0]       src_d;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant     <= '0;
            last_q    <= LAST_RESET;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state_q   <= state_d;
            grant     <= grant_d;
            last_q    <= last_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_src   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req != '0) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_WAIT;
            ST_WAIT:  if (out_ready) state_d = (req != '0) ? ST_DRIVE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant defaults low so it can only stay up for the single DRIVE cycle.
    always_comb begin
        grant_d = '0;
        last_d  = last_q;
        valid_d = out_valid;
        data_d  = out_data;
        src_d   = out_src;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    grant_d = pick;
                    last_d  = pick;
                end
            end
            ST_DRIVE: begin
                data_d  = bus_data;
                src_d   = grant;
                valid_d = 1'b1;
            end
            ST_WAIT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (req != '0) begin
                        grant_d = pick;
                        last_d  = pick;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic, checked against
// a transaction-level round-robin model and an expected-beat queue.
module tb_mem_bus_arbiter;

    localparam int WIDTH = 64;
    localparam logic [WIDTH-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       grant;
    logic [WIDTH-1:0] bus_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_src;

    logic [WIDTH-1:0] bus_val [4];
    logic [WIDTH+3:0] exp_q [$];
    int               total = 0;
    int               bad = 0;
    int               last_m = 3;
    logic             prev_gnz = 1'b0;
    logic [3:0]       req_prev = 4'b0;

    mem_bus_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .bus_data  (bus_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester side: only the granted requester drives; otherwise the bus carries junk.
    always_comb begin
        bus_data = JUNK;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) bus_data = bus_val[i];
        end
    end

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rr_next(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return 4'(1 << ((last + k) % 4));
        end
        return 4'b0;
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    always @(posedge rst) begin
        exp_q.delete();
        last_m   = 3;
        prev_gnz = 1'b0;
    end

    // Protocol monitor: round-robin order, grant shape, and beat delivery order.
    always @(negedge clk) begin
        logic [3:0] exp_g;
        if (!rst) begin
            chk("onehot0", 68'($onehot0(grant)), 68'(1));
            if (grant != 4'b0) begin
                chk("no_b2b_grant", 68'(prev_gnz), 68'(0));
                exp_g = rr_next(last_m, req_prev);
                chk("rr_grant", 68'(grant), 68'(exp_g));
                if (exp_g != 4'b0) begin
                    last_m = oh2idx(exp_g);
                    exp_q.push_back({exp_g, bus_val[last_m]});
                end
            end
            if (out_valid) begin
                chk("valid_has_beat", 68'(exp_q.size() != 0), 68'(1));
                if (exp_q.size() != 0) begin
                    chk("mon_out_data", 68'(out_data), 68'(exp_q[0][WIDTH-1:0]));
                    chk("mon_out_src", 68'(out_src), 68'(exp_q[0][WIDTH+3:WIDTH]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_gnz = (grant != 4'b0);
            req_prev = req;
        end
    end

    initial begin
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b0;
        req = 4'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_val[i] = 64'h1111_0000 + 64'(i);
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_grant", 68'(grant), 68'(0));
        chk("rst_valid", 68'(out_valid), 68'(0));
        chk("rst_data", 68'(out_data), 68'(0));
        chk("rst_src", 68'(out_src), 68'(0));
        rst = 1'b0;
        step();

        // Single beat with latency check
        bus_val[2] = 64'hDEAD_BEEF;
        req = 4'b0100;
        step();
        chk("t2_grant", 68'(grant), 68'(4'b0100));
        chk("t2_valid_early", 68'(out_valid), 68'(0));
        req = 4'b0;
        step();
        chk("t2_grant_off", 68'(grant), 68'(0));
        chk("t2_valid", 68'(out_valid), 68'(1));
        chk("t2_data", 68'(out_data), 68'(64'hDEAD_BEEF));
        chk("t2_src", 68'(out_src), 68'(4'b0100));
        step();
        chk("t2_hold_valid", 68'(out_valid), 68'(1));
        out_ready = 1'b1;
        step();
        chk("t2_consumed", 68'(out_valid), 68'(0));
        out_ready = 1'b0;

        // Reset pulse mid-idle clears held outputs before the next edge
        #2 rst = 1'b1;
        #1;
        chk("t1_grant", 68'(grant), 68'(0));
        chk("t1_valid", 68'(out_valid), 68'(0));
        chk("t1_data", 68'(out_data), 68'(0));
        chk("t1_src", 68'(out_src), 68'(0));
        #1 rst = 1'b0;
        step();

        // All requesting, consumer always ready
        bus_val[2] = 64'h1111_0002;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_grant", 68'(grant), 68'(seq[k]));
            if (k == 4) req = 4'b0;
            step();
            chk("t3_gap", 68'(grant), 68'(0));
            chk("t3_valid", 68'(out_valid), 68'(1));
            chk("t3_src", 68'(out_src), 68'(seq[k]));
            chk("t3_data", 68'(out_data), 68'(bus_val[oh2idx(seq[k])]));
        end
        step();
        chk("t3_idle_valid", 68'(out_valid), 68'(0));
        chk("t3_idle_grant", 68'(grant), 68'(0));
        out_ready = 1'b0;

        // Backpressure
        req = 4'b0011;
        step();
        chk("t4_grant", 68'(grant), 68'(4'b0010));
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_valid", 68'(out_valid), 68'(1));
            chk("t4_data", 68'(out_data), 68'(bus_val[1]));
            chk("t4_src", 68'(out_src), 68'(4'b0010));
            chk("t4_grant_low", 68'(grant), 68'(0));
        end
        out_ready = 1'b1;
        step();
        chk("t4_next_grant", 68'(grant), 68'(4'b0001));
        chk("t4_valid_drop", 68'(out_valid), 68'(0));
        req = 4'b0;
        step();
        chk("t4_src2", 68'(out_src), 68'(4'b0001));
        step();

        // Wrap-around
        req = 4'b1000;
        step();
        chk("t5_grant_1000", 68'(grant), 68'(4'b1000));
        req = 4'b1001;
        step();
        step();
        chk("t5_wrap", 68'(grant), 68'(4'b0001));
        step();
        step();
        chk("t5_after_wrap", 68'(grant), 68'(4'b1000));
        req = 4'b0;
        step();
        step();

        // Async reset mid-DRIVE
        req = 4'b0100;
        step();
        chk("t6_grant", 68'(grant), 68'(4'b0100));
        #2 rst = 1'b1;
        #1;
        chk("t6_grant_drop", 68'(grant), 68'(0));
        chk("t6_valid", 68'(out_valid), 68'(0));
        req = 4'b0110;
        step();
        rst = 1'b0;
        step();
        chk("t6_first_grant", 68'(grant), 68'(4'b0010));
        req = 4'b0;
        step();
        step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!grant[i]) bus_val[i] = {$urandom, $urandom};
            end
            step();
        end

        req = 4'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_queue", 68'(exp_q.size()), 68'(0));
        chk("drain_valid", 68'(out_valid), 68'(0));
        chk("drain_grant", 68'(grant), 68'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
